mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Memory-stage load/store unit, sitting directly upstream of the memory-stage pipeline register.
- Issues aligned 64-bit data-memory requests over a valid/ready handshake and stalls the pipeline until the response returns.
- Produces sign/zero-extended load data (read_data) and misalignment exception causes, both consumed by the memory-stage register.

Parameters:
DATA_WIDTH, 64, data bus and register width (fixed at 64; byte-enable logic assumes 8 lanes)
ADDR_WIDTH, 64, byte address width
TIMEOUT_CYCLES, 255, cycle limit used only when the timeout feature is compiled in

Ports:
i_clk  input  1  clock
i_arst  input  1  reset, asynchronous, active-high
i_valid  input  1  valid instruction present in memory stage
i_mem_re  input  1  instruction is a load
i_mem_we  input  1  instruction is a store (priority over i_mem_re)
i_funct3  input  3  access size/sign (RV64 load/store funct3)
i_addr  input  ADDR_WIDTH  effective byte address (ALU result)
i_store_data  input  DATA_WIDTH  rs2 store data, right-aligned
o_req_valid  output  1  memory request valid
i_req_ready  input  1  memory accepts request
o_req_we  output  1  request is a write
o_req_addr  output  ADDR_WIDTH  i_addr with bits [2:0] cleared
o_req_wdata  output  DATA_WIDTH  store data shifted to byte lane
o_req_be  output  8  byte enables
i_resp_valid  input  1  response/write-ack valid
i_resp_rdata  input  DATA_WIDTH  raw 64-bit read data
o_read_data  output  DATA_WIDTH  extended load result
o_stall_mem  output  1  stall all stages up to and including memory stage
o_exc_valid  output  1  memory exception for current instruction
o_cause  output  4  exception cause code

Behaviour:
Reset (i_arst=1, any time, including mid-transaction):
- State -> IDLE; all outputs 0.
- A response arriving afterwards is ignored (i_resp_valid ignored outside WAIT).

Request terms:
- access = i_valid & (i_mem_re | i_mem_we).
- Size = funct3[1:0]: 0=B, 1=H, 2=W, 3=D.
- Misaligned when H & addr[0], W & addr[1:0]!=0, or D & addr[2:0]!=0.

Misaligned access (IDLE only):
- No request issued, no stall.
- o_exc_valid=1 combinationally; o_cause=6 for a store, 4 for a load.
- State stays IDLE.

FSM IDLE/REQ/WAIT/DONE:
- IDLE: on aligned access -> REQ. Latch we, addr, be, wdata, funct3.
- REQ: o_req_valid=1 with latched fields, held stable until i_req_ready=1, then -> WAIT.
- WAIT: on i_resp_valid=1 -> DONE. Loads capture the extended data into o_read_data register; stores wait for the ack only.
- DONE: stall released for one cycle while the downstream register captures; -> IDLE unconditionally. In DONE, access is masked so the still-present instruction is not re-issued.

Stall and latency:
- o_stall_mem = (IDLE & aligned access) | REQ | WAIT.
- Minimum latency: 3 stall cycles (ready and response each in the first cycle they are possible), then DONE.

Data path:
- o_req_be = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0].
- o_req_wdata = i_store_data << (8*addr[2:0]).

Load extraction:
- Shift rdata right by 8*addr[2:0].
- funct3 000/001/010 sign-extend; 100/101/110 zero-extend; 011 and 111 full 64 bits.
- o_read_data holds its last value until the next load completes.

o_exc_valid outside a misaligned IDLE cycle: 0, unless the timeout feature fires.

Optional Feature:
MEM_ACCESS_TIMEOUT_EN
- Defined:
  - 8-bit+ counter clears on entering REQ and counts in REQ and WAIT.
  - When it reaches TIMEOUT_CYCLES -> DONE with o_exc_valid=1 for the DONE cycle; o_cause=7 for a store, 5 for a load; o_read_data=0.
  - o_req_valid drops.
  - A late response is ignored.
- Undefined: no counter; the FSM waits indefinitely in REQ/WAIT.

Decomposition:
- Package mem_access_pkg: state enum (IDLE, REQ, WAIT, DONE); funct3 localparams (LB..LWU, SB..SD); cause localparams (LOAD_MISALIGN=4, LOAD_FAULT=5, STORE_MISALIGN=6, STORE_FAULT=7); size-mask function.
- Sub-module mem_load_align: combinational shift plus sign/zero extension, inputs rdata/offset/funct3, output 64-bit data.

Test Plan:
- Aligned load: LW (funct3 010) at 0x1004, ready immediate, resp one cycle later with rdata=0x8000_0000_1234_5678 -> be=0xF0, addr=0x1000, stall for 3 cycles, o_read_data=0xFFFF_FFFF_8000_0000.
- Byte loads: LB at 0x2007 with rdata[63:56]=0x9C -> 0xFFFF_FFFF_FFFF_FF9C; LBU at the same address -> 0x9C.
- Store with backpressure: SH (001) at 0x3002, data 0xABCD, ready low 3 cycles -> req fields stable throughout, be=0x0C, wdata=0xABCD_0000; stall until the ack, then one DONE cycle.
- Misaligned: LW at 0x1002 -> no o_req_valid, o_stall_mem=0, o_exc_valid=1, o_cause=4; SD at 0x1004 -> o_cause=6.
- Reset mid-transaction: assert i_arst in WAIT, then send i_resp_valid -> state IDLE, all outputs 0, response ignored, next LD completes normally.
- Timeout (MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=16): load with no response -> DONE after 16 counted cycles, o_exc_valid=1, o_cause=5, o_read_data=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
// Holds the FSM state encoding, RV64 funct3 codes, exception causes and
// the byte-lane helpers used by both the request and load-extract paths.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Load funct3 encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    // Store funct3 encodings
    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;
    localparam logic [2:0] SD = 3'b011;

    // Exception cause codes
    localparam logic [3:0] LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] LOAD_FAULT     = 4'd5;
    localparam logic [3:0] STORE_MISALIGN = 4'd6;
    localparam logic [3:0] STORE_FAULT    = 4'd7;

    // Byte-lane mask for an access size at lane offset zero
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            2'd0:    mask = 8'h01;
            2'd1:    mask = 8'h03;
            2'd2:    mask = 8'h0F;
            2'd3:    mask = 8'hFF;
            default: mask = 8'h00;
        endcase
        return mask;
    endfunction

    // An access is misaligned when it would straddle its natural boundary
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = off[0];
            2'd2:    mis = (off[1:0] != 2'b00);
            2'd3:    mis = (off != 3'b000);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data extraction: moves the addressed bytes of a 64-bit read word
// down to bit 0 and sign/zero-extends them according to funct3.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    output logic [63:0] data
);

    logic [63:0] shifted_s;

    assign shifted_s = rdata >> {offset, 3'b000};

    // Select width and extension; LD and the 111 encoding pass all 64 bits
    always_comb begin
        data = shifted_s;
        case (funct3)
            LB:      data = {{56{shifted_s[7]}},  shifted_s[7:0]};
            LH:      data = {{48{shifted_s[15]}}, shifted_s[15:0]};
            LW:      data = {{32{shifted_s[31]}}, shifted_s[31:0]};
            LBU:     data = {56'd0, shifted_s[7:0]};
            LHU:     data = {48'd0, shifted_s[15:0]};
            LWU:     data = {32'd0, shifted_s[31:0]};
            default: data = shifted_s;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit. Issues one aligned 64-bit request per
// load/store over a valid/ready handshake, stalls the pipeline until the
// response or write ack returns, and flags misaligned accesses.
// Optional build macro MEM_ACCESS_TIMEOUT_EN adds a response timeout that
// ends the transaction with a fault cause after TIMEOUT_CYCLES cycles.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_valid,
    input  logic                  i_mem_re,
    input  logic                  i_mem_we,
    input  logic [2:0]            i_funct3,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_store_data,
    output logic                  o_req_valid,
    input  logic                  i_req_ready,
    output logic                  o_req_we,
    output logic [ADDR_WIDTH-1:0] o_req_addr,
    output logic [DATA_WIDTH-1:0] o_req_wdata,
    output logic [7:0]            o_req_be,
    input  logic                  i_resp_valid,
    input  logic [DATA_WIDTH-1:0] i_resp_rdata,
    output logic [DATA_WIDTH-1:0] o_read_data,
    output logic                  o_stall_mem,
    output logic                  o_exc_valid,
    output logic [3:0]            o_cause
);

    state_t                  state_r;
    state_t                  state_s;
    logic                    we_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [2:0]              off_r;
    logic [7:0]              be_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [2:0]              funct3_r;
    logic [DATA_WIDTH-1:0]   read_data_r;
    logic [DATA_WIDTH-1:0]   load_data_s;
    logic                    access_s;
    logic                    misalign_s;
    logic                    start_s;
    logic                    mis_exc_s;
    logic                    resp_take_s;
    logic                    timeout_hit_s;
    logic                    to_exc_s;

    // Access is masked while reset is held so every output reads 0 then
    assign access_s    = i_valid & (i_mem_re | i_mem_we) & ~i_arst;
    assign misalign_s  = is_misaligned(i_funct3[1:0], i_addr[2:0]);
    assign start_s     = (state_r == IDLE) & access_s & ~misalign_s;
    assign mis_exc_s   = (state_r == IDLE) & access_s & misalign_s;
    assign resp_take_s = (state_r == WAIT) & i_resp_valid & ~timeout_hit_s;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_r;
    logic        timeout_r;

    assign timeout_hit_s = ((state_r == REQ) | (state_r == WAIT)) & (cnt_r == TO_LAST);
    assign to_exc_s      = (state_r == DONE) & timeout_r;

    // Timeout counter: cleared on entry to REQ, counts every REQ/WAIT cycle
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            cnt_r     <= 16'd0;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timeout_hit_s;
            if (start_s) begin
                cnt_r <= 16'd0;
            end else if ((state_r == REQ) | (state_r == WAIT)) begin
                cnt_r <= cnt_r + 16'd1;
            end
        end
    end
`else
    assign timeout_hit_s = 1'b0;
    assign to_exc_s      = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a timeout takes precedence over a same-cycle handshake
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (timeout_hit_s) begin
                    state_s = DONE;
                end else if (i_req_ready) begin
                    state_s = WAIT;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (timeout_hit_s) begin
                    state_s = DONE;
                end else if (i_resp_valid) begin
                    state_s = DONE;
                end else begin
                    state_s = WAIT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Request fields are latched once in IDLE so they stay stable under backpressure
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            we_r     <= 1'b0;
            addr_r   <= {ADDR_WIDTH{1'b0}};
            off_r    <= 3'd0;
            be_r     <= 8'd0;
            wdata_r  <= {DATA_WIDTH{1'b0}};
            funct3_r <= 3'd0;
        end else if (start_s) begin
            we_r     <= i_mem_we;
            addr_r   <= {i_addr[ADDR_WIDTH-1:3], 3'b000};
            off_r    <= i_addr[2:0];
            be_r     <= size_mask(i_funct3[1:0]) << i_addr[2:0];
            wdata_r  <= i_store_data << {i_addr[2:0], 3'b000};
            funct3_r <= i_funct3;
        end
    end

    mem_load_align u_load_align (
        .rdata  (i_resp_rdata),
        .offset (off_r),
        .funct3 (funct3_r),
        .data   (load_data_s)
    );

    // Load result register: updated on load completion, zeroed on a load timeout
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            read_data_r <= {DATA_WIDTH{1'b0}};
        end else if (resp_take_s & ~we_r) begin
            read_data_r <= load_data_s;
        end else if (timeout_hit_s & ~we_r) begin
            read_data_r <= {DATA_WIDTH{1'b0}};
        end
    end

    assign o_req_valid = (state_r == REQ);
    assign o_req_we    = we_r;
    assign o_req_addr  = addr_r;
    assign o_req_be    = be_r;
    assign o_req_wdata = wdata_r;
    assign o_read_data = read_data_r;
    assign o_stall_mem = start_s | (state_r == REQ) | (state_r == WAIT);
    assign o_exc_valid = mis_exc_s | to_exc_s;

    // Cause code: misalignment reflects the incoming instruction, faults the latched one
    always_comb begin
        o_cause = 4'd0;
        if (mis_exc_s) begin
            o_cause = i_mem_we ? STORE_MISALIGN : LOAD_MISALIGN;
        end else if (to_exc_s) begin
            o_cause = we_r ? STORE_FAULT : LOAD_FAULT;
        end else begin
            o_cause = 4'd0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a table of directed load/store
// vectors with hand-computed results, plus hand-written sequences for
// backpressure, reset mid-transaction and the (optional) response timeout.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        arst;
    logic        valid, mem_re, mem_we;
    logic [2:0]  funct3;
    logic [63:0] addr, store_data;
    logic        req_valid, req_ready, req_we;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_be;
    logic        resp_valid;
    logic [63:0] resp_rdata, read_data;
    logic        stall, exc_valid;
    logic [3:0]  cause;

    int checks = 0;
    int errors = 0;
    logic [63:0] last_rd = 64'd0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .TIMEOUT_CYCLES(16)) dut (
        .i_clk(clk), .i_arst(arst), .i_valid(valid), .i_mem_re(mem_re), .i_mem_we(mem_we),
        .i_funct3(funct3), .i_addr(addr), .i_store_data(store_data),
        .o_req_valid(req_valid), .i_req_ready(req_ready), .o_req_we(req_we),
        .o_req_addr(req_addr), .o_req_wdata(req_wdata), .o_req_be(req_be),
        .i_resp_valid(resp_valid), .i_resp_rdata(resp_rdata), .o_read_data(read_data),
        .o_stall_mem(stall), .o_exc_valid(exc_valid), .o_cause(cause)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] sdata;
        logic [63:0] rdata;
        logic        mis;
        logic [3:0]  cause;
        logic [7:0]  be;
        logic [63:0] raddr;
        logic [63:0] wdata;
        logic [63:0] rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [63:0] a,
                                input logic [63:0] sd, input logic [63:0] rdat, input logic mis,
                                input logic [3:0] c, input logic [7:0] be, input logic [63:0] ra,
                                input logic [63:0] wd, input logic [63:0] rd);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = a; v.sdata = sd; v.rdata = rdat; v.mis = mis;
        v.cause = c; v.be = be; v.raddr = ra; v.wdata = wd; v.rd = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full transaction with immediate ready and response (minimum latency)
    task automatic run_vec(input vec_t v, input int idx);
        int stalls;
        int seen;
        int budget;
        valid = 1'b1; mem_we = v.we; mem_re = ~v.we; funct3 = v.f3; addr = v.addr;
        store_data = v.sdata; req_ready = 1'b1; resp_valid = 1'b1; resp_rdata = v.rdata;
        #1;
        if (v.mis) begin
            check($sformatf("v%0d mis_exc", idx), {63'd0, exc_valid}, 64'd1);
            check($sformatf("v%0d mis_cause", idx), {60'd0, cause}, {60'd0, v.cause});
            check($sformatf("v%0d mis_stall", idx), {63'd0, stall}, 64'd0);
            check($sformatf("v%0d mis_reqv", idx), {63'd0, req_valid}, 64'd0);
            tick;
            check($sformatf("v%0d mis_idle_reqv", idx), {63'd0, req_valid}, 64'd0);
            check($sformatf("v%0d mis_rd_hold", idx), read_data, last_rd);
        end else begin
            check($sformatf("v%0d exc_idle", idx), {63'd0, exc_valid}, 64'd0);
            stalls = 0; seen = 0; budget = 20;
            while (stall && budget > 0) begin
                if (req_valid) begin
                    seen++;
                    check($sformatf("v%0d be", idx), {56'd0, req_be}, {56'd0, v.be});
                    check($sformatf("v%0d raddr", idx), req_addr, v.raddr);
                    check($sformatf("v%0d we", idx), {63'd0, req_we}, {63'd0, v.we});
                    if (v.we) check($sformatf("v%0d wdata", idx), req_wdata, v.wdata);
                end
                stalls++; budget--;
                tick;
            end
            if (!v.we) last_rd = v.rd;
            check($sformatf("v%0d stall_cycles", idx), 64'(stalls), 64'd3);
            check($sformatf("v%0d req_seen", idx), 64'(seen), 64'd1);
            check($sformatf("v%0d read_data", idx), read_data, last_rd);
            check($sformatf("v%0d done_exc", idx), {63'd0, exc_valid}, 64'd0);
            valid = 1'b0;
            tick;
            check($sformatf("v%0d idle_stall", idx), {63'd0, stall}, 64'd0);
            check($sformatf("v%0d idle_reqv", idx), {63'd0, req_valid}, 64'd0);
        end
        valid = 1'b0; req_ready = 1'b0; resp_valid = 1'b0;
    endtask

    initial begin
        int stalls;
        vec_t ld_vec;
        arst = 1'b1; valid = 1'b0; mem_re = 1'b0; mem_we = 1'b0; funct3 = 3'd0;
        addr = 64'd0; store_data = 64'd0; req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = 64'd0;

        //          we    f3      addr          sdata                  rdata                  mis  cause  be     raddr         wdata                  rd
        vecs.push_back(mk(1'b0, 3'b010, 64'h1004, 64'd0, 64'h8000_0000_1234_5678, 1'b0, 4'd0, 8'hF0, 64'h1000, 64'd0, 64'hFFFF_FFFF_8000_0000));
        vecs.push_back(mk(1'b0, 3'b000, 64'h2007, 64'd0, 64'h9C00_0000_0000_0000, 1'b0, 4'd0, 8'h80, 64'h2000, 64'd0, 64'hFFFF_FFFF_FFFF_FF9C));
        vecs.push_back(mk(1'b0, 3'b100, 64'h2007, 64'd0, 64'h9C00_0000_0000_0000, 1'b0, 4'd0, 8'h80, 64'h2000, 64'd0, 64'h0000_0000_0000_009C));
        vecs.push_back(mk(1'b0, 3'b001, 64'h2006, 64'd0, 64'hF00D_0000_0000_0000, 1'b0, 4'd0, 8'hC0, 64'h2000, 64'd0, 64'hFFFF_FFFF_FFFF_F00D));
        vecs.push_back(mk(1'b0, 3'b101, 64'h2002, 64'd0, 64'h0000_0000_BEEF_0000, 1'b0, 4'd0, 8'h0C, 64'h2000, 64'd0, 64'h0000_0000_0000_BEEF));
        vecs.push_back(mk(1'b0, 3'b110, 64'h1004, 64'd0, 64'h8000_0000_1234_5678, 1'b0, 4'd0, 8'hF0, 64'h1000, 64'd0, 64'h0000_0000_8000_0000));
        vecs.push_back(mk(1'b0, 3'b011, 64'h4008, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 4'd0, 8'hFF, 64'h4008, 64'd0, 64'h0123_4567_89AB_CDEF));
        vecs.push_back(mk(1'b1, 3'b010, 64'h5004, 64'hDEAD_BEEF, 64'd0, 1'b0, 4'd0, 8'hF0, 64'h5000, 64'hDEAD_BEEF_0000_0000, 64'd0));
        vecs.push_back(mk(1'b1, 3'b000, 64'h5003, 64'h0000_0000_0000_00A5, 64'd0, 1'b0, 4'd0, 8'h08, 64'h5000, 64'h0000_0000_A500_0000, 64'd0));
        vecs.push_back(mk(1'b1, 3'b011, 64'h6000, 64'h1122_3344_5566_7788, 64'd0, 1'b0, 4'd0, 8'hFF, 64'h6000, 64'h1122_3344_5566_7788, 64'd0));
        vecs.push_back(mk(1'b0, 3'b000, 64'h2000, 64'd0, 64'hFFFF_FFFF_FFFF_FF7F, 1'b0, 4'd0, 8'h01, 64'h2000, 64'd0, 64'h0000_0000_0000_007F));
        vecs.push_back(mk(1'b0, 3'b010, 64'h1002, 64'd0, 64'd0, 1'b1, 4'd4, 8'h00, 64'd0, 64'd0, 64'd0));
        vecs.push_back(mk(1'b1, 3'b011, 64'h1004, 64'd0, 64'd0, 1'b1, 4'd6, 8'h00, 64'd0, 64'd0, 64'd0));
        vecs.push_back(mk(1'b0, 3'b001, 64'h1001, 64'd0, 64'd0, 1'b1, 4'd4, 8'h00, 64'd0, 64'd0, 64'd0));
        vecs.push_back(mk(1'b1, 3'b010, 64'h1006, 64'd0, 64'd0, 1'b1, 4'd6, 8'h00, 64'd0, 64'd0, 64'd0));
        vecs.push_back(mk(1'b0, 3'b011, 64'h1004, 64'd0, 64'd0, 1'b1, 4'd4, 8'h00, 64'd0, 64'd0, 64'd0));
        ld_vec = vecs[6];

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_reqv", {63'd0, req_valid}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_rd", read_data, 64'd0);
        arst = 1'b0;
        tick;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Store with backpressure: ready low for three REQ cycles
        valid = 1'b1; mem_we = 1'b1; mem_re = 1'b0; funct3 = 3'b001; addr = 64'h3002;
        store_data = 64'hABCD; req_ready = 1'b0; resp_valid = 1'b0;
        #1;
        check("bp_idle_stall", {63'd0, stall}, 64'd1);
        check("bp_idle_reqv", {63'd0, req_valid}, 64'd0);
        tick;
        for (int c = 0; c < 3; c++) begin
            check("bp_reqv", {63'd0, req_valid}, 64'd1);
            check("bp_stall", {63'd0, stall}, 64'd1);
            check("bp_be", {56'd0, req_be}, 64'h0C);
            check("bp_addr", req_addr, 64'h3000);
            check("bp_wdata", req_wdata, 64'hABCD_0000);
            check("bp_we", {63'd0, req_we}, 64'd1);
            addr = 64'h9999_0000; store_data = 64'hFFFF_FFFF;
            tick;
        end
        req_ready = 1'b1;
        #1;
        check("bp_hs_reqv", {63'd0, req_valid}, 64'd1);
        check("bp_hs_wdata", req_wdata, 64'hABCD_0000);
        tick;
        req_ready = 1'b0;
        check("bp_wait_reqv", {63'd0, req_valid}, 64'd0);
        check("bp_wait_stall", {63'd0, stall}, 64'd1);
        tick;
        check("bp_wait2_stall", {63'd0, stall}, 64'd1);
        resp_valid = 1'b1;
        tick;
        check("bp_done_stall", {63'd0, stall}, 64'd0);
        check("bp_done_exc", {63'd0, exc_valid}, 64'd0);
        check("bp_done_rd_hold", read_data, last_rd);
        valid = 1'b0; resp_valid = 1'b0;
        tick;
        check("bp_idle_after", {63'd0, stall}, 64'd0);

        // Reset while waiting for a load response
        valid = 1'b1; mem_we = 1'b0; mem_re = 1'b1; funct3 = 3'b011; addr = 64'h7000;
        req_ready = 1'b1; resp_valid = 1'b0; resp_rdata = 64'h5555_AAAA_5555_AAAA;
        tick;
        tick;
        check("rw_wait_stall", {63'd0, stall}, 64'd1);
        check("rw_wait_reqv", {63'd0, req_valid}, 64'd0);
        #1 arst = 1'b1;
        #1;
        check("rw_reqv", {63'd0, req_valid}, 64'd0);
        check("rw_stall", {63'd0, stall}, 64'd0);
        check("rw_exc", {63'd0, exc_valid}, 64'd0);
        check("rw_cause", {60'd0, cause}, 64'd0);
        check("rw_rd", read_data, 64'd0);
        check("rw_addr", req_addr, 64'd0);
        check("rw_be", {56'd0, req_be}, 64'd0);
        check("rw_wdata", req_wdata, 64'd0);
        check("rw_we", {63'd0, req_we}, 64'd0);
        valid = 1'b0;
        tick;
        arst = 1'b0;
        resp_valid = 1'b1;
        tick;
        check("rw_late_stall", {63'd0, stall}, 64'd0);
        check("rw_late_rd", read_data, 64'd0);
        tick;
        check("rw_late_reqv", {63'd0, req_valid}, 64'd0);
        resp_valid = 1'b0; req_ready = 1'b0;
        last_rd = 64'd0;
        run_vec(ld_vec, 100);

        // Load with no response
        valid = 1'b1; mem_we = 1'b0; mem_re = 1'b1; funct3 = 3'b010; addr = 64'h1004;
        req_ready = 1'b1; resp_valid = 1'b0; resp_rdata = 64'h8000_0000_1234_5678;
        #1;
`ifdef MEM_ACCESS_TIMEOUT_EN
        stalls = 0;
        for (int c = 0; c < 100; c++) begin
            if (!stall) break;
            stalls++;
            tick;
        end
        check("to_stall_cycles", 64'(stalls), 64'd17);
        check("to_exc", {63'd0, exc_valid}, 64'd1);
        check("to_cause", {60'd0, cause}, 64'd5);
        check("to_rd", read_data, 64'd0);
        check("to_reqv", {63'd0, req_valid}, 64'd0);
        valid = 1'b0;
        tick;
        check("to_idle_exc", {63'd0, exc_valid}, 64'd0);
        resp_valid = 1'b1;
        tick;
        check("to_late_stall", {63'd0, stall}, 64'd0);
        check("to_late_rd", read_data, 64'd0);
        resp_valid = 1'b0;
`else
        stalls = 0;
        for (int c = 0; c < 300; c++) begin
            if (!stall) break;
            stalls++;
            tick;
        end
        check("nto_still_stalled", {63'd0, stall}, 64'd1);
        check("nto_exc", {63'd0, exc_valid}, 64'd0);
        resp_valid = 1'b1;
        tick;
        check("nto_done_stall", {63'd0, stall}, 64'd0);
        check("nto_done_rd", read_data, 64'hFFFF_FFFF_8000_0000);
        valid = 1'b0; resp_valid = 1'b0;
        tick;
`endif
        req_ready = 1'b0;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
